// File: rtl/fwd_width_adapter_pkg.sv
// Shared helpers for the forwarder/packet-memory width adapter: ratio and
// select-width derivation plus the big-endian slice-index convention.
`ifndef FWD_WIDTH_ADAPTER_PKG_SV
`define FWD_WIDTH_ADAPTER_PKG_SV

// Slice k of a wide word, slice 0 in the most-significant position.
`define FWD_SLICE(data, k, mw, fw) data[(mw)-1-(k)*(fw) -: (fw)]

package fwd_width_adapter_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int ratio_of(input int mem_w, input int fwd_w);
        return mem_w / fwd_w;
    endfunction

    function automatic int sel_w_of(input int mem_w, input int fwd_w);
        return clog2(mem_w / fwd_w);
    endfunction

    function automatic int slice_msb(input int k, input int mem_w, input int fwd_w);
        return mem_w - 1 - k * fwd_w;
    endfunction

endpackage

`endif

// File: rtl/fwd_sel_delay.sv
// Fixed-depth shift register with asynchronous active-low clear; carries the
// slice select alongside the packet-memory read latency.
module fwd_sel_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
        end else begin
            stage_p[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
    end

    assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/fwd_width_adapter.sv
// Read-path width adapter: forwarder word address -> packet-memory address,
// returning the requested big-endian slice after the memory latency.
// Optional output register: define FWD_WIDTH_ADAPTER_OREG_EN (latency MEM_LAT+1).
module fwd_width_adapter
    import fwd_width_adapter_pkg::*;
#(
    parameter int MEM_WIDTH      = 64,
    parameter int FWD_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 9,
    parameter int FWD_ADDR_WIDTH = 10,
    parameter int MEM_LAT        = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FWD_ADDR_WIDTH-1:0] fwd_addr,
    output logic [FWD_WIDTH-1:0]      fwd_rd_data,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_WIDTH-1:0]      mem_rd_data
);

    localparam int RATIO = ratio_of(MEM_WIDTH, FWD_WIDTH);
    localparam int SEL_W = sel_w_of(MEM_WIDTH, FWD_WIDTH);

    if (MEM_WIDTH % FWD_WIDTH != 0) begin : g_chk_multiple
        $fatal(1, "MEM_WIDTH must be an integer multiple of FWD_WIDTH");
    end
    if ((RATIO & (RATIO - 1)) != 0) begin : g_chk_pow2
        $fatal(1, "MEM_WIDTH/FWD_WIDTH must be a power of two");
    end
    if (FWD_ADDR_WIDTH != MEM_ADDR_WIDTH + SEL_W) begin : g_chk_addr
        $fatal(1, "FWD_ADDR_WIDTH must equal MEM_ADDR_WIDTH + clog2(ratio)");
    end
    if (MEM_LAT < 1) begin : g_chk_lat
        $fatal(1, "MEM_LAT must be at least 1");
    end

    logic [FWD_WIDTH-1:0] rd_comb;

    if (SEL_W == 0) begin : g_pass
        assign mem_addr = fwd_addr;
        assign rd_comb  = mem_rd_data;
    end else begin : g_split
        logic [SEL_W-1:0] sel_q;

        assign mem_addr = fwd_addr[FWD_ADDR_WIDTH-1:SEL_W];

        // Select travels with the read so back-to-back addresses never see a stale slice.
        fwd_sel_delay #(
            .WIDTH (SEL_W),
            .DEPTH (MEM_LAT)
        ) u_sel_delay (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (fwd_addr[SEL_W-1:0]),
            .q     (sel_q)
        );

        always_comb begin
            rd_comb = `FWD_SLICE(mem_rd_data, 0, MEM_WIDTH, FWD_WIDTH);
            for (int k = 1; k < RATIO; k++) begin
                if (sel_q == SEL_W'(k)) rd_comb = `FWD_SLICE(mem_rd_data, k, MEM_WIDTH, FWD_WIDTH);
            end
        end
    end

`ifdef FWD_WIDTH_ADAPTER_OREG_EN
    // ---- output register stage: one cycle after the select pipeline ----
    logic [FWD_WIDTH-1:0] rd_data_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_p1 <= '0;
        else        rd_data_p1 <= rd_comb;
    end

    assign fwd_rd_data = rd_data_p1;
`else
    assign fwd_rd_data = rd_comb;
`endif

endmodule

// File: tb/tb_fwd_width_adapter.sv
// Directed/random bench for fwd_width_adapter against a byte-addressed
// reference model of the packet memory (byte i holds i & 0xFF).
module tb_fwd_width_adapter;

    localparam int MW     = 64;
    localparam int FW     = 32;
    localparam int MAW    = 9;
    localparam int FAW    = 10;
    localparam int ML     = 1;
    localparam int SELW   = 1;
    localparam int NBYTES = FW / 8;
`ifdef FWD_WIDTH_ADAPTER_OREG_EN
    localparam int OREG = 1;
`else
    localparam int OREG = 0;
`endif
    localparam int LAT   = ML + OREG;
    localparam int DEPTH = 1024;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [FAW-1:0] fwd_addr = '0;
    logic [FW-1:0]  fwd_rd_data;
    logic [MAW-1:0] mem_addr;
    logic [MW-1:0]  mem_rd_data;
    logic [MW-1:0]  mem_pipe [ML];

    logic [FAW-1:0] rec_addr [DEPTH];
    bit             rec_rst  [DEPTH];
    int             cyc = 0;
    int             n_chk = 0;
    int             n_pass = 0;

    fwd_width_adapter #(
        .MEM_WIDTH      (MW),
        .FWD_WIDTH      (FW),
        .MEM_ADDR_WIDTH (MAW),
        .FWD_ADDR_WIDTH (FAW),
        .MEM_LAT        (ML)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fwd_addr    (fwd_addr),
        .fwd_rd_data (fwd_rd_data),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [MW-1:0] mem_word(input logic [MAW-1:0] w);
        logic [MW-1:0] r;
        r = '0;
        for (int b = 0; b < MW / 8; b++) r = (r << 8) | MW'((int'(w) * (MW / 8) + b) & 255);
        return r;
    endfunction

    // Forwarder word a is simply bytes NBYTES*a .. NBYTES*a+NBYTES-1, MSB first.
    function automatic logic [FW-1:0] fwd_word(input logic [FAW-1:0] a);
        logic [FW-1:0] r;
        r = '0;
        for (int i = 0; i < NBYTES; i++) r = (r << 8) | FW'((int'(a) * NBYTES + i) & 255);
        return r;
    endfunction

    // Combinational result after posedge c: the address seen ML-1 edges earlier,
    // with its slice forced to 0 if reset was low anywhere in that window.
    function automatic logic [FW-1:0] exp_comb(input int c);
        int             first;
        bit             cleared;
        logic [FAW-1:0] a;
        first   = c - ML + 1;
        cleared = 1'b0;
        for (int j = first; j <= c; j++) if (!rec_rst[j]) cleared = 1'b1;
        a = rec_addr[first];
        if (cleared) a = a & ~FAW'((1 << SELW) - 1);
        return fwd_word(a);
    endfunction

    always @(posedge clk) begin
        for (int i = ML - 1; i > 0; i--) mem_pipe[i] <= mem_pipe[i-1];
        mem_pipe[0] <= mem_word(mem_addr);
    end
    assign mem_rd_data = mem_pipe[ML-1];

    always @(posedge clk) begin
        if (cyc < DEPTH - 1) begin
            cyc = cyc + 1;
            rec_addr[cyc] = fwd_addr;
            rec_rst[cyc]  = rst_n;
        end
    end

    task automatic check_out();
        int            c;
        logic [FW-1:0] expv;
        c = cyc;
        if (c >= LAT) begin
            if (OREG != 0) expv = rec_rst[c] ? exp_comb(c - 1) : '0;
            else           expv = exp_comb(c);
            n_chk++;
            assert (fwd_rd_data === expv) n_pass++;
            else $error("FAIL rd_data cyc=%0d observed=%h expected=%h", c, fwd_rd_data, expv);
        end
    endtask

    task automatic step(input logic [FAW-1:0] a, input logic r);
        logic [MAW-1:0] expa;
        @(negedge clk);
        check_out();
        fwd_addr = a;
        rst_n    = r;
        #1;
        expa = MAW'(a >> SELW);
        n_chk++;
        assert (mem_addr === expa) n_pass++;
        else $error("FAIL mem_addr addr=%h observed=%h expected=%h", a, mem_addr, expa);
    endtask

    initial begin
        for (int i = 0; i < ML; i++) mem_pipe[i] = '0;
        rst_n    = 1'b0;
        fwd_addr = '0;

        repeat (3) step(FAW'(0), 1'b0);
        step(FAW'(0), 1'b1);
        step(FAW'(1), 1'b1);
        step(FAW'(0), 1'b1);

        for (int k = 0; k < 16; k++) begin
            int hold;
            hold = int'($urandom_range(1, 3));
            repeat (hold) step(FAW'(k), 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            logic [FAW-1:0] a;
            a = (i == 20) ? FAW'(10'h3FF) : FAW'($urandom_range(0, (1 << FAW) - 1));
            step(a, 1'b1);
        end

        step(FAW'(3), 1'b1);
        step(FAW'(3), 1'b0);
        step(FAW'(3), 1'b0);
        step(FAW'(3), 1'b1);
        step(FAW'(3), 1'b1);
        step(FAW'(2), 1'b1);

        for (int i = 0; i < 10; i++) step(FAW'($urandom_range(0, (1 << FAW) - 1)), 1'b1);
        repeat (LAT + 1) step(FAW'(1023), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
